xor_requester: RTL and testbench
================================

# xor_requester

Test-side initiator for the XOR datapath. Accepts operand pairs on a command port, drives them onto the 1-bit A and B enable/ready interfaces of the XOR unit, and consumes Y results. Each result is checked against an internally queued expected value (a XOR b) and reported on a response port with an error flag. Sits opposite the XOR unit: its A/B outputs connect to the unit's A/B inputs, and its Y inputs connect to the unit's Y outputs.

## Interface
- DEPTH, 4: maximum outstanding requests (expected-result FIFO entries), power of two, ≥2
- CNT_W, 16: width of the sent and error counters
- TIMEOUT_CYCLES, 256: watchdog limit (only with macro)
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- cmd_valid  input  1  operand pair offered
- cmd_ready  output  1  operand pair accepted when cmd_valid&cmd_ready
- cmd_a, cmd_b  input  1 each  operands
- A_data, B_data  output  1 each  operand to XOR unit
- A_enable, B_enable  output  1 each  transfer strobe, asserted only while matching *_ready high
- A_ready, B_ready  input  1 each  XOR unit can take operand
- Y_data  input  1  result from XOR unit
- Y_enable  input  1  result strobe; XOR unit asserts only while Y_ready high
- Y_ready  output  1  requester can take result
- rsp_valid, rsp_data, rsp_error  output  1 each  checked result; rsp_error=1 on mismatch
- rsp_ready  input  1  response consumed
- sent_count, err_count  output  CNT_W each  completed commands / mismatches
- timeout  output  1  sticky watchdog flag (0 when macro absent)

## Operation
- Transfer rule, all ports: a transfer occurs in any cycle where the strobe/valid and ready are both high. One transfer per cycle per port.
- States: IDLE, ISSUE.
  - IDLE: cmd_ready = ~fifo_full. On accept: latch a/b into A_data/B_data registers, set a_pend=b_pend=1, push cmd_a^cmd_b into the expected FIFO, go to ISSUE.
  - ISSUE: A_enable = a_pend & A_ready (combinational). B_enable = b_pend & B_ready. A and B may transfer in different cycles. Each transfer clears its pend flag. When both flags are clear (including both clearing in the same cycle), go to IDLE. cmd_ready=0.
- Y_ready = ~fifo_empty & (~rsp_valid | rsp_ready).
- On a Y transfer: pop the expected FIFO. Load rsp_data=Y_data and rsp_error=(Y_data != expected). Set rsp_valid. Increment sent_count. Increment err_count on mismatch.
- rsp_valid clears on rsp_ready unless a new Y transfer reloads it in the same cycle.
- Counters saturate at all-ones.
- FIFO push and pop in the same cycle: allowed, occupancy unchanged. Push is never attempted when full, because cmd_ready is gated.
- Y_enable with an empty FIFO is a protocol violation. Ignore it: no pop, no response.
- Reset values: cmd_ready=0 during reset, then 1 from the first cycle after release. A/B_data=0, A/B_enable=0, Y_ready=0, rsp_valid/data/error=0, counters=0, timeout=0, state=IDLE, FIFO empty.

## Timing
- Command accepted at cycle N; A/B_enable can first assert at N+1.
- Return to IDLE at the cycle after the last A/B transfer. Peak rate: one command per 2 cycles.
- Y transfer at cycle M gives rsp_valid at M+1.
- Reset mid-ISSUE or with responses outstanding: everything is discarded immediately (asynchronous). Expected entries already in flight are dropped.

## Configuration
- XOR_REQ_TIMEOUT_EN defined:
  - A watchdog counter runs while the FIFO is non-empty and no Y transfer occurs. It resets on any Y transfer or when the FIFO is empty.
  - When it reaches TIMEOUT_CYCLES, timeout sets and stays set until reset. Traffic continues.
- Macro undefined: no counter logic; timeout tied to 0.

## Structure
- Shared package xor_req_pkg holds:
  - the state enum (IDLE, ISSUE)
  - default DEPTH, CNT_W, TIMEOUT_CYCLES constants
- Sub-module xor_req_fifo: 1-bit-wide, DEPTH-entry synchronous FIFO holding expected results.
  - Read/write pointers with one extra wrap bit.
  - Provides full and empty flags.
  - Same clk/reset_n.

## Test plan
- Single command a=1,b=0, A/B_ready and rsp_ready held high, unit returns Y=1 -> A/B_enable pulse at N+1, rsp_valid with data=1, error=0, sent_count=1.
- A_ready high, B_ready held low 5 cycles -> A transfers at N+1, B_enable stays 0 until B_ready rises, cmd_ready stays 0 until the cycle after B transfers.
- Issue 4 commands (DEPTH=4) with Y withheld -> 5th cmd_valid sees cmd_ready=0. One Y transfer -> cmd_ready returns next cycle.
- Y returns the wrong value for pair (1,1) -> rsp_data=1, rsp_error=1, err_count=1.
- rsp_ready low with one response pending and more outstanding -> Y_ready=0. rsp_ready high -> Y_ready=1 the same cycle and back-to-back responses.
- reset_n low mid-ISSUE with 2 outstanding -> all outputs return to reset values asynchronously. After release, a fresh command completes normally. With XOR_REQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, withholding Y for 8 cycles -> timeout=1 and stays set.

Source files
------------

// File: rtl/xor_req_pkg.sv
// Shared types and default parameters for the XOR requester and its FIFO.
package xor_req_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam int DEFAULT_DEPTH          = 4;
  localparam int DEFAULT_CNT_W          = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/xor_req_fifo.sv
// 1-bit-wide synchronous FIFO holding the expected XOR results of requests
// in flight. Pointers carry one extra wrap bit to tell full from empty.
module xor_req_fifo
  import xor_req_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  logic wdata,
  input  logic pop,
  output logic rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [DEPTH-1:0] mem;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Advance pointers and store entries; reset drops everything in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/xor_requester.sv
// Test-side initiator for the XOR unit: issues operand pairs on A/B, checks
// each Y result against the queued expected a^b and reports it on rsp.
// Optional watchdog enabled by defining XOR_REQ_TIMEOUT_EN.
module xor_requester
  import xor_req_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = DEFAULT_CNT_W
`ifdef XOR_REQ_TIMEOUT_EN
  ,parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_a,
  input  logic             cmd_b,
  output logic             A_data,
  output logic             A_enable,
  input  logic             A_ready,
  output logic             B_data,
  output logic             B_enable,
  input  logic             B_ready,
  input  logic             Y_data,
  input  logic             Y_enable,
  output logic             Y_ready,
  output logic             rsp_valid,
  output logic             rsp_data,
  output logic             rsp_error,
  input  logic             rsp_ready,
  output logic [CNT_W-1:0] sent_count,
  output logic [CNT_W-1:0] err_count,
  output logic             timeout
);

  state_t state;
  state_t next_state;
  logic   a_pend;
  logic   b_pend;
  logic   started;
  logic   cmd_fire;
  logic   y_xfer;
  logic   y_mismatch;
  logic   fifo_exp;
  logic   fifo_full;
  logic   fifo_empty;

  assign cmd_fire   = cmd_valid & cmd_ready;
  assign Y_ready    = ~fifo_empty & (~rsp_valid | rsp_ready);
  assign y_xfer     = Y_enable & Y_ready;
  assign y_mismatch = (Y_data != fifo_exp);

  xor_req_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (cmd_fire),
    .wdata  (cmd_a ^ cmd_b),
    .pop    (y_xfer),
    .rdata  (fifo_exp),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Holds cmd_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) started <= 1'b0;
    else          started <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Leave IDLE on accept; leave ISSUE once both operands have been taken.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cmd_fire) next_state = ISSUE;
      ISSUE:   if ((~a_pend | A_enable) & (~b_pend | B_enable)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs: accept only in IDLE with FIFO room, strobe only in ISSUE.
  always_comb begin
    cmd_ready = 1'b0;
    A_enable  = 1'b0;
    B_enable  = 1'b0;
    case (state)
      IDLE:  cmd_ready = started & ~fifo_full;
      ISSUE: begin
        A_enable = a_pend & A_ready;
        B_enable = b_pend & B_ready;
      end
      default: cmd_ready = 1'b0;
    endcase
  end

  // Latch operands on accept and clear each pending flag as its side transfers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      A_data <= 1'b0;
      B_data <= 1'b0;
      a_pend <= 1'b0;
      b_pend <= 1'b0;
    end else if (cmd_fire) begin
      A_data <= cmd_a;
      B_data <= cmd_b;
      a_pend <= 1'b1;
      b_pend <= 1'b1;
    end else begin
      if (A_enable) a_pend <= 1'b0;
      if (B_enable) b_pend <= 1'b0;
    end
  end

  // Check each Y result, present it on rsp and update saturating counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid  <= 1'b0;
      rsp_data   <= 1'b0;
      rsp_error  <= 1'b0;
      sent_count <= '0;
      err_count  <= '0;
    end else if (y_xfer) begin
      rsp_valid <= 1'b1;
      rsp_data  <= Y_data;
      rsp_error <= y_mismatch;
      if (~&sent_count) sent_count <= sent_count + CNT_W'(1);
      if (y_mismatch && ~&err_count) err_count <= err_count + CNT_W'(1);
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef XOR_REQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  // Count cycles spent waiting on an outstanding result; flag sticks once hit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else if (fifo_empty || y_xfer) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_W'(TIMEOUT_CYCLES)) begin
      wd_cnt <= wd_cnt + WD_W'(1);
      if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_xor_requester.sv
// Self-checking bench for xor_requester. The bench plays the XOR unit by
// hand; a scoreboard queue holds expected responses, checked as they drain.
module tb_xor_requester;

`ifdef XOR_REQ_TIMEOUT_EN
  localparam logic EXP_TO = 1'b1;
`else
  localparam logic EXP_TO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_a, cmd_b;
  logic        A_data, A_enable, A_ready;
  logic        B_data, B_enable, B_ready;
  logic        Y_data, Y_enable, Y_ready;
  logic        rsp_valid, rsp_data, rsp_error, rsp_ready;
  logic [15:0] sent_count, err_count;
  logic        timeout;

  int          total = 0;
  int          passed = 0;
  int          exp_sent = 0;
  int          exp_err = 0;
  int          w;
  logic        op_q[$];
  logic [1:0]  rsp_q[$];
  logic [1:0]  mon_exp;

  xor_requester #(
    .DEPTH(4),
    .CNT_W(16)
`ifdef XOR_REQ_TIMEOUT_EN
    ,.TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .A_data(A_data), .A_enable(A_enable), .A_ready(A_ready),
    .B_data(B_data), .B_enable(B_enable), .B_ready(B_ready),
    .Y_data(Y_data), .Y_enable(Y_enable), .Y_ready(Y_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error), .rsp_ready(rsp_ready),
    .sent_count(sent_count), .err_count(err_count), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Scoreboard: every consumed response must match the oldest expected entry.
  always @(negedge clk) begin
    #2;
    if (reset_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      total++;
      if (rsp_q.size() == 0) begin
        $display("[TB] FAIL rsp_unexpected got data=%b err=%b want none", rsp_data, rsp_error);
      end else begin
        mon_exp = rsp_q.pop_front();
        if ({rsp_data, rsp_error} !== mon_exp)
          $display("[TB] FAIL rsp_check got data/err=%b want %b", {rsp_data, rsp_error}, mon_exp);
        else passed++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got no finish want finish");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic send_cmd(input logic a, input logic b);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b;
    #1;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
    total++;
    if (cmd_ready !== 1'b1) begin
      $display("[TB] FAIL cmd_accept got cmd_ready=%b want 1", cmd_ready);
      cmd_valid = 1'b0;
    end else begin
      passed++;
      op_q.push_back(a ^ b);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic give_y(input logic y, input logic rr, output int waited);
    logic x;
    waited = 0;
    @(negedge clk);
    rsp_ready = rr; Y_enable = 1'b1; Y_data = y;
    #1;
    while (Y_ready !== 1'b1 && waited < 50) begin @(negedge clk); #1; waited++; end
    total++;
    if (Y_ready !== 1'b1 || op_q.size() == 0) begin
      $display("[TB] FAIL y_accept got Y_ready=%b pending=%0d want 1", Y_ready, op_q.size());
    end else begin
      passed++;
      x = op_q.pop_front();
      rsp_q.push_back({y, y != x});
      exp_sent++;
      if (y != x) exp_err++;
      @(posedge clk); #1;
    end
    Y_enable = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_a = 1'b0; cmd_b = 1'b0;
    A_ready = 1'b0; B_ready = 1'b0; Y_data = 1'b0; Y_enable = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (cmd_ready !== 1'b0) $display("[TB] FAIL reset_cmd_ready got %b want 0", cmd_ready); else passed++;
    total++;
    if ({A_enable, B_enable, A_data, B_data, Y_ready, rsp_valid, rsp_data, rsp_error} !== 8'b0)
      $display("[TB] FAIL reset_outputs got %b want 00000000",
               {A_enable, B_enable, A_data, B_data, Y_ready, rsp_valid, rsp_data, rsp_error});
    else passed++;
    total++; if (sent_count !== 16'd0) $display("[TB] FAIL reset_sent got %0d want 0", sent_count); else passed++;
    total++; if (err_count !== 16'd0) $display("[TB] FAIL reset_err got %0d want 0", err_count); else passed++;
    total++; if (timeout !== 1'b0) $display("[TB] FAIL reset_timeout got %b want 0", timeout); else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    total++; if (cmd_ready !== 1'b1) $display("[TB] FAIL release_cmd_ready got %b want 1", cmd_ready); else passed++;
  endtask

  task automatic test_single();
    A_ready = 1'b1; B_ready = 1'b1; rsp_ready = 1'b1;
    send_cmd(1'b1, 1'b0);
    @(negedge clk); #1;
    total++;
    if ({A_enable, B_enable, A_data, B_data, cmd_ready} !== 5'b11100)
      $display("[TB] FAIL single_issue got en/data/ready=%b want 11100", {A_enable, B_enable, A_data, B_data, cmd_ready});
    else passed++;
    give_y(1'b1, 1'b1, w);
    @(negedge clk); #1;
    total++; if (rsp_valid !== 1'b1) $display("[TB] FAIL single_rsp_valid got %b want 1", rsp_valid); else passed++;
    total++; if (sent_count !== 16'd1) $display("[TB] FAIL single_sent got %0d want 1", sent_count); else passed++;
    total++;
    if ({A_enable, B_enable, cmd_ready} !== 3'b001)
      $display("[TB] FAIL single_idle got en/ready=%b want 001", {A_enable, B_enable, cmd_ready});
    else passed++;
  endtask

  task automatic test_b_stall();
    A_ready = 1'b1; B_ready = 1'b0; rsp_ready = 1'b1;
    send_cmd(1'b0, 1'b1);
    @(negedge clk); #1;
    total++;
    if ({A_enable, B_enable, cmd_ready} !== 3'b100)
      $display("[TB] FAIL stall_first got en/ready=%b want 100", {A_enable, B_enable, cmd_ready});
    else passed++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      total++;
      if ({A_enable, B_enable, cmd_ready} !== 3'b000)
        $display("[TB] FAIL stall_hold%0d got en/ready=%b want 000", i, {A_enable, B_enable, cmd_ready});
      else passed++;
    end
    @(negedge clk);
    B_ready = 1'b1;
    #1;
    total++;
    if ({B_enable, B_data, cmd_ready} !== 3'b110)
      $display("[TB] FAIL stall_b_release got en/data/ready=%b want 110", {B_enable, B_data, cmd_ready});
    else passed++;
    @(negedge clk); #1;
    total++; if (cmd_ready !== 1'b1) $display("[TB] FAIL stall_done got cmd_ready=%b want 1", cmd_ready); else passed++;
    give_y(1'b1, 1'b1, w);
  endtask

  task automatic test_full();
    A_ready = 1'b1; B_ready = 1'b1; rsp_ready = 1'b1;
    send_cmd(1'b0, 1'b0);
    send_cmd(1'b0, 1'b1);
    send_cmd(1'b1, 1'b0);
    send_cmd(1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_a = 1'b1; cmd_b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (cmd_ready !== 1'b0) $display("[TB] FAIL full_block%0d got cmd_ready=%b want 0", i, cmd_ready); else passed++;
      if (i == 0) @(negedge clk);
    end
    cmd_valid = 1'b0;
    give_y(1'b0, 1'b1, w);
    @(negedge clk); #1;
    total++; if (cmd_ready !== 1'b1) $display("[TB] FAIL full_reopen got cmd_ready=%b want 1", cmd_ready); else passed++;
    send_cmd(1'b1, 1'b0);
    while (op_q.size() > 0) give_y(op_q[0], 1'b1, w);
    @(negedge clk); #1;
    total++;
    if (sent_count !== 16'(exp_sent)) $display("[TB] FAIL full_sent got %0d want %0d", sent_count, exp_sent); else passed++;
  endtask

  task automatic test_mismatch();
    A_ready = 1'b1; B_ready = 1'b1; rsp_ready = 1'b1;
    send_cmd(1'b1, 1'b1);
    give_y(1'b1, 1'b1, w);
    total++;
    if ({rsp_valid, rsp_data, rsp_error} !== 3'b111)
      $display("[TB] FAIL mismatch_rsp got valid/data/err=%b want 111", {rsp_valid, rsp_data, rsp_error});
    else passed++;
    total++;
    if (err_count !== 16'(exp_err)) $display("[TB] FAIL mismatch_err_count got %0d want %0d", err_count, exp_err); else passed++;
  endtask

  task automatic test_backpressure();
    A_ready = 1'b1; B_ready = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    send_cmd(1'b0, 1'b1);
    send_cmd(1'b1, 1'b0);
    give_y(1'b1, 1'b0, w);
    @(negedge clk); #1;
    total++;
    if ({Y_ready, rsp_valid} !== 2'b01)
      $display("[TB] FAIL bp_stall got Y_ready/rsp_valid=%b want 01", {Y_ready, rsp_valid});
    else passed++;
    give_y(1'b1, 1'b1, w);
    total++; if (w !== 0) $display("[TB] FAIL bp_same_cycle got wait=%0d want 0", w); else passed++;
    @(negedge clk); #1;
    total++; if (rsp_valid !== 1'b1) $display("[TB] FAIL bp_back_to_back got rsp_valid=%b want 1", rsp_valid); else passed++;
  endtask

  task automatic test_timeout();
    A_ready = 1'b1; B_ready = 1'b1; rsp_ready = 1'b1;
    send_cmd(1'b1, 1'b1);
    repeat (7) @(posedge clk);
    #1;
    total++; if (timeout !== 1'b0) $display("[TB] FAIL timeout_early got %b want 0", timeout); else passed++;
    @(posedge clk); #1;
    total++; if (timeout !== EXP_TO) $display("[TB] FAIL timeout_hit got %b want %b", timeout, EXP_TO); else passed++;
    give_y(1'b0, 1'b1, w);
    repeat (3) @(negedge clk);
    #1;
    total++; if (timeout !== EXP_TO) $display("[TB] FAIL timeout_sticky got %b want %b", timeout, EXP_TO); else passed++;
  endtask

  task automatic test_reset_mid();
    A_ready = 1'b1; B_ready = 1'b1; rsp_ready = 1'b0;
    send_cmd(1'b1, 1'b0);
    @(posedge clk); #1;
    B_ready = 1'b0;
    send_cmd(1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    B_ready = 1'b1;
    #1;
    total++; if (B_enable !== 1'b1) $display("[TB] FAIL mid_issue got B_enable=%b want 1", B_enable); else passed++;
    #2;
    reset_n = 1'b0;
    #1;
    op_q.delete(); rsp_q.delete(); exp_sent = 0; exp_err = 0;
    total++;
    if ({cmd_ready, A_enable, B_enable, A_data, B_data, Y_ready, rsp_valid, rsp_data, rsp_error} !== 9'b0)
      $display("[TB] FAIL mid_reset_outputs got %b want 000000000",
               {cmd_ready, A_enable, B_enable, A_data, B_data, Y_ready, rsp_valid, rsp_data, rsp_error});
    else passed++;
    total++;
    if ({sent_count, err_count, timeout} !== 33'b0)
      $display("[TB] FAIL mid_reset_counts got sent=%0d err=%0d to=%b want 0 0 0", sent_count, err_count, timeout);
    else passed++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    total++; if (cmd_ready !== 1'b1) $display("[TB] FAIL mid_release got cmd_ready=%b want 1", cmd_ready); else passed++;
    rsp_ready = 1'b1;
    send_cmd(1'b0, 1'b1);
    give_y(1'b1, 1'b1, w);
    @(negedge clk); #1;
    total++;
    if ({sent_count, err_count} !== {16'd1, 16'd0})
      $display("[TB] FAIL mid_fresh got sent=%0d err=%0d want 1 0", sent_count, err_count);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_b_stall();
    test_full();
    test_mismatch();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (op_q.size() != 0 || rsp_q.size() != 0)
      $display("[TB] FAIL drain got pending=%0d responses=%0d want 0 0", op_q.size(), rsp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
